// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings for the hazard/stall controller: FSM states, decode field
// positions, the NOP word and the performance-counter width.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN          = 2'b00,
    ST_DSTALL       = 2'b01,
    ST_ISTALL       = 2'b10,
    ST_ISTALL_REDIR = 2'b11
  } stall_state_t;

  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;

  localparam logic [15:0] NOP = 16'h0000;

  localparam int CNT_W = 16;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating event counters for stall/flush activity (built only when
// HAZARD_PERF_CNT_EN is defined).
module hazard_perf_counters
  import hazard_stall_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             lu_evt,
  input  logic             dm_evt,
  input  logic             im_evt,
  input  logic             fl_evt,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] dmem_stall_cnt,
  output logic [CNT_W-1:0] imem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt   <= '0;
      dmem_stall_cnt <= '0;
      imem_stall_cnt <= '0;
      flush_cnt      <= '0;
    end else begin
      if (lu_evt) lu_stall_cnt   <= sat_inc(lu_stall_cnt);
      if (dm_evt) dmem_stall_cnt <= sat_inc(dmem_stall_cnt);
      if (im_evt) imem_stall_cnt <= sat_inc(imem_stall_cnt);
      if (fl_evt) flush_cnt      <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use, D-miss freeze, I-miss bubbles and
// redirect flushes. Define HAZARD_PERF_CNT_EN to add saturating perf counters.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_W   = 3,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] ID_Instr,
  input  logic               ID_usesRs,
  input  logic               ID_usesRt,
  input  logic               IE_memRead,
  input  logic               IE_regWrite,
  input  logic [REG_W-1:0]   IE_writereg,
  input  logic               IE_pcSrc,
  input  logic               imem_busy,
  input  logic               dmem_busy,
  output logic               pc_write_en,
  output logic               IF_ID_write_en,
  output logic               IF_ID_flush,
  output logic               ID_IE_write_en,
  output logic               ID_IE_bubble,
  output logic               IE_M_write_en,
  output logic               M_WB_bubble,
  output logic [1:0]         stall_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   lu_stall_cnt,
  output logic [CNT_W-1:0]   dmem_stall_cnt,
  output logic [CNT_W-1:0]   imem_stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  stall_state_t state, nxt_state;
  stall_state_t ret_state, nxt_ret_state;
  stall_state_t eff_state;

  logic [RS_HI-RS_LO:0] id_rs;
  logic [RT_HI-RT_LO:0] id_rt;
  logic                 load_use;
  logic                 unused_instr_bits;

  assign id_rs = ID_Instr[RS_HI:RS_LO];
  assign id_rt = ID_Instr[RT_HI:RT_LO];
  assign unused_instr_bits = ^{ID_Instr[INSTR_W-1:RS_HI+1], ID_Instr[RT_LO-1:0]};

  assign load_use = IE_memRead && IE_regWrite &&
                    ((ID_usesRs && (IE_writereg == id_rs)) ||
                     (ID_usesRt && (IE_writereg == id_rt)));

  // Leaving DSTALL resumes the saved state in the same cycle, so a pending
  // redirect or finished I-miss is handled as soon as the freeze lifts.
  assign eff_state = (state == ST_DSTALL) ? ret_state : state;

  always_comb begin
    pc_write_en    = 1'b1;
    IF_ID_write_en = 1'b1;
    IF_ID_flush    = 1'b0;
    ID_IE_write_en = 1'b1;
    ID_IE_bubble   = 1'b0;
    IE_M_write_en  = 1'b1;
    M_WB_bubble    = 1'b0;
    nxt_state      = eff_state;
    nxt_ret_state  = ret_state;
    if (rst) begin
      nxt_state     = ST_RUN;
      nxt_ret_state = ST_RUN;
    end else if (dmem_busy) begin
      pc_write_en    = 1'b0;
      IF_ID_write_en = 1'b0;
      ID_IE_write_en = 1'b0;
      IE_M_write_en  = 1'b0;
      M_WB_bubble    = 1'b1;
      nxt_state      = ST_DSTALL;
      if (state != ST_DSTALL) nxt_ret_state = state;
    end else if (IE_pcSrc) begin
      IF_ID_flush  = 1'b1;
      ID_IE_bubble = 1'b1;
      nxt_state    = imem_busy ? ST_ISTALL_REDIR : ST_RUN;
    end else if (load_use) begin
      pc_write_en    = 1'b0;
      IF_ID_write_en = 1'b0;
      ID_IE_bubble   = 1'b1;
    end else if (imem_busy) begin
      pc_write_en = 1'b0;
      IF_ID_flush = 1'b1;
      nxt_state   = (eff_state == ST_ISTALL_REDIR) ? ST_ISTALL_REDIR : ST_ISTALL;
    end else begin
      // The word arriving as a redirected miss ends is wrong-path; drop it.
      if (eff_state == ST_ISTALL_REDIR) IF_ID_flush = 1'b1;
      nxt_state = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
    end else begin
      state     <= nxt_state;
      ret_state <= nxt_ret_state;
    end
  end

  assign stall_state = state;

`ifdef HAZARD_PERF_CNT_EN
  logic lu_evt, dm_evt, im_evt, fl_evt;

  assign dm_evt = !rst && dmem_busy;
  assign fl_evt = !rst && !dmem_busy && IE_pcSrc;
  assign lu_evt = !rst && !dmem_busy && !IE_pcSrc && load_use;
  assign im_evt = !rst && !dmem_busy && !IE_pcSrc && !load_use && imem_busy;

  hazard_perf_counters u_perf (
    .clk           (clk),
    .rst           (rst),
    .lu_evt        (lu_evt),
    .dm_evt        (dm_evt),
    .im_evt        (im_evt),
    .fl_evt        (fl_evt),
    .lu_stall_cnt  (lu_stall_cnt),
    .dmem_stall_cnt(dmem_stall_cnt),
    .imem_stall_cnt(imem_stall_cnt),
    .flush_cnt     (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a flag-based model.
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst;
  logic [15:0] ID_Instr;
  logic        ID_usesRs, ID_usesRt;
  logic        IE_memRead, IE_regWrite;
  logic [2:0]  IE_writereg;
  logic        IE_pcSrc, imem_busy, dmem_busy;
  logic        pc_write_en, IF_ID_write_en, IF_ID_flush;
  logic        ID_IE_write_en, ID_IE_bubble, IE_M_write_en, M_WB_bubble;
  logic [1:0]  stall_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: "in a D-miss", "in an I-miss", "I-miss with redirect pending".
  bit m_dmiss = 0;
  bit m_imiss = 0;
  bit m_redir = 0;

  hazard_stall_unit dut (
    .clk           (clk),
    .rst           (rst),
    .ID_Instr      (ID_Instr),
    .ID_usesRs     (ID_usesRs),
    .ID_usesRt     (ID_usesRt),
    .IE_memRead    (IE_memRead),
    .IE_regWrite   (IE_regWrite),
    .IE_writereg   (IE_writereg),
    .IE_pcSrc      (IE_pcSrc),
    .imem_busy     (imem_busy),
    .dmem_busy     (dmem_busy),
    .pc_write_en   (pc_write_en),
    .IF_ID_write_en(IF_ID_write_en),
    .IF_ID_flush   (IF_ID_flush),
    .ID_IE_write_en(ID_IE_write_en),
    .ID_IE_bubble  (ID_IE_bubble),
    .IE_M_write_en (IE_M_write_en),
    .M_WB_bubble   (M_WB_bubble),
    .stall_state   (stall_state)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit dm, input bit im, input bit br,
                     input bit mr, input bit rw, input logic [2:0] wr,
                     input logic [15:0] ins, input bit urs, input bit urt);
    @(posedge clk);
    #1;
    rst = r; dmem_busy = dm; imem_busy = im; IE_pcSrc = br;
    IE_memRead = mr; IE_regWrite = rw; IE_writereg = wr;
    ID_Instr = ins; ID_usesRs = urs; ID_usesRt = urt;
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
  endtask

  // Reference model: evaluated on the falling edge, when inputs are stable.
  always @(negedge clk) begin
    if (chk_en) begin
      int  rs, rt, e_st;
      bit  lu;
      bit  e_pc, e_ifw, e_iff, e_idw, e_idb, e_iew, e_mwb;
      e_pc = 1; e_ifw = 1; e_iff = 0; e_idw = 1; e_idb = 0; e_iew = 1; e_mwb = 0;
      e_st = m_dmiss ? 1 : (m_redir ? 3 : (m_imiss ? 2 : 0));
      rs = (int'(ID_Instr) >> 8) % 8;
      rt = (int'(ID_Instr) >> 5) % 8;
      lu = IE_memRead && IE_regWrite &&
           ((ID_usesRs && int'(IE_writereg) == rs) || (ID_usesRt && int'(IE_writereg) == rt));
      if (rst) begin
        m_dmiss = 0; m_imiss = 0; m_redir = 0;
      end else if (dmem_busy) begin
        e_pc = 0; e_ifw = 0; e_idw = 0; e_iew = 0; e_mwb = 1;
        m_dmiss = 1;
      end else begin
        m_dmiss = 0;
        if (IE_pcSrc) begin
          e_iff = 1; e_idb = 1;
          m_imiss = imem_busy; m_redir = imem_busy;
        end else if (lu) begin
          e_pc = 0; e_ifw = 0; e_idb = 1;
        end else if (imem_busy) begin
          e_pc = 0; e_iff = 1;
          m_imiss = 1;
        end else begin
          if (m_redir) e_iff = 1;
          m_imiss = 0; m_redir = 0;
        end
      end
      cmp("stall_state", stall_state, e_st);
      cmp("pc_write_en", pc_write_en, e_pc);
      cmp("IF_ID_write_en", IF_ID_write_en, e_ifw);
      cmp("IF_ID_flush", IF_ID_flush, e_iff);
      cmp("ID_IE_write_en", ID_IE_write_en, e_idw);
      cmp("ID_IE_bubble", ID_IE_bubble, e_idb);
      cmp("IE_M_write_en", IE_M_write_en, e_iew);
      cmp("M_WB_bubble", M_WB_bubble, e_mwb);
    end
  end

  initial begin
    rst = 1; dmem_busy = 0; imem_busy = 0; IE_pcSrc = 0;
    IE_memRead = 0; IE_regWrite = 0; IE_writereg = 0;
    ID_Instr = 0; ID_usesRs = 0; ID_usesRt = 0;
    chk_en = 1;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    idle();
    cmp("rst_state", stall_state, 0);
    cmp("rst_pc_we", pc_write_en, 1);
    cmp("rst_iem_we", IE_M_write_en, 1);
    cmp("rst_mwb_bub", M_WB_bubble, 0);

    // Load-use on rs
    cyc(0, 0, 0, 0, 1, 1, 3'd3, 16'h0300, 1, 0);
    cmp("lu_pc_we", pc_write_en, 0);
    cmp("lu_ifid_we", IF_ID_write_en, 0);
    cmp("lu_idie_bub", ID_IE_bubble, 1);
    idle();
    cmp("lu_after_pc_we", pc_write_en, 1);
    cmp("lu_after_ifid_we", IF_ID_write_en, 1);
    cmp("lu_after_bub", ID_IE_bubble, 0);

    // D-miss for 5 cycles
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
      cmp("dm_pc_we", pc_write_en, 0);
      cmp("dm_idie_we", ID_IE_write_en, 0);
      cmp("dm_iem_we", IE_M_write_en, 0);
      cmp("dm_mwb_bub", M_WB_bubble, 1);
      cmp("dm_state", stall_state, (i == 0) ? 0 : 1);
    end
    idle();
    cmp("dm_drop_mwb_bub", M_WB_bubble, 0);
    cmp("dm_drop_iem_we", IE_M_write_en, 1);
    idle();
    cmp("dm_run_state", stall_state, 0);

    // I-miss for 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
      cmp("im_pc_we", pc_write_en, 0);
      cmp("im_ifid_flush", IF_ID_flush, 1);
      cmp("im_idie_we", ID_IE_write_en, 1);
    end
    idle();
    cmp("im_end_pc_we", pc_write_en, 1);
    cmp("im_end_flush", IF_ID_flush, 0);
    idle();
    cmp("im_run_state", stall_state, 0);

    // Redirect during I-miss
    cyc(0, 0, 1, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 3'd0, 16'h0000, 0, 0);
    cmp("rd_pc_we", pc_write_en, 1);
    cmp("rd_flush", IF_ID_flush, 1);
    cyc(0, 0, 1, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    cmp("rd_state", stall_state, 3);
    cmp("rd_busy_pc_we", pc_write_en, 0);
    idle();
    cmp("rd_fall_flush", IF_ID_flush, 1);
    cmp("rd_fall_pc_we", pc_write_en, 1);
    idle();
    cmp("rd_run_state", stall_state, 0);
    cmp("rd_run_flush", IF_ID_flush, 0);

    // Branch together with a matching load-use on rt
    cyc(0, 0, 0, 1, 1, 1, 3'd5, 16'h00A0, 0, 1);
    cmp("brlu_pc_we", pc_write_en, 1);
    cmp("brlu_ifid_we", IF_ID_write_en, 1);
    cmp("brlu_flush", IF_ID_flush, 1);
    cmp("brlu_bub", ID_IE_bubble, 1);

    // D-miss entered from an I-miss returns to the I-miss
    cyc(0, 0, 1, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    cmp("dmim_ret_pc_we", pc_write_en, 0);
    cyc(0, 0, 1, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    cmp("dmim_ret_state", stall_state, 2);
    idle();

    // Reset during D-stall
    cyc(0, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    cmp("rds_state", stall_state, 1);
    cyc(1, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
    idle();
    cmp("rds_after_state", stall_state, 0);
    cmp("rds_after_pc_we", pc_write_en, 1);
    cmp("rds_after_idie_we", ID_IE_write_en, 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit r, dm, im, br, mr, rw, urs, urt;
      r   = ($urandom_range(0, 199) == 0);
      dm  = ($urandom_range(0, 99) < 15);
      im  = ($urandom_range(0, 99) < 25);
      br  = ($urandom_range(0, 99) < 10);
      mr  = ($urandom_range(0, 99) < 50);
      rw  = ($urandom_range(0, 99) < 80);
      urs = ($urandom_range(0, 99) < 70);
      urt = ($urandom_range(0, 99) < 50);
      cyc(r, dm, im, br, mr, rw, 3'($urandom_range(0, 7)), 16'($urandom), urs, urt);
    end
    idle();
    @(posedge clk);
    #1;
    chk_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side partner of the EX-stage bypass network.
- Resolves every hazard that bypassing cannot: load-use RAW, data-cache miss freeze, instruction-cache miss bubbles, and branch/jump redirect flushes.
- Sits beside the IF/ID, ID/IE, IE/M and M/WB pipeline registers and drives their write-enable and bubble/flush controls.
- Holds a small FSM so that a redirect arriving during an I-cache miss discards the wrong-path fetch.

Parameters:
- REG_W, 3, register-specifier width.
- INSTR_W, 16, instruction width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ID_Instr  in  INSTR_W  instruction in decode; rs=[10:8], rt=[7:5].
- ID_usesRs  in  1  decode instruction reads rs.
- ID_usesRt  in  1  decode instruction reads rt.
- IE_memRead  in  1  instruction in EX is a load.
- IE_regWrite  in  1  instruction in EX writes a register.
- IE_writereg  in  REG_W  destination of the EX instruction.
- IE_pcSrc  in  1  EX resolved a taken branch or jump.
- imem_busy  in  1  I-cache miss in progress; fetch data invalid.
- dmem_busy  in  1  D-cache miss in progress; M-stage data invalid.
- pc_write_en  out  1  PC may update.
- IF_ID_write_en  out  1  IF/ID register may load.
- IF_ID_flush  out  1  load a NOP into IF/ID.
- ID_IE_write_en  out  1  ID/IE register may load.
- ID_IE_bubble  out  1  load a NOP into ID/IE.
- IE_M_write_en  out  1  IE/M register may load.
- M_WB_bubble  out  1  load a NOP into M/WB.
- stall_state  out  2  current FSM state, for debug.

Behaviour:
- Reset:
  - State = RUN.
  - All *_write_en = 1; all flush/bubble = 0; stall_state = 2'b00.
  - A reset mid-stall returns to RUN next cycle and discards any pending redirect.
- States: RUN=00, DSTALL=01, ISTALL=10, ISTALL_REDIR=11. All outputs are combinational from state plus inputs; the state register updates on posedge clk.
- load_use condition: IE_memRead & IE_regWrite & ((ID_usesRs & IE_writereg==rs) | (ID_usesRt & IE_writereg==rt)).
- Priority, highest first: dmem_busy, IE_pcSrc, load_use, imem_busy.
- dmem_busy (any state):
  - Freeze: pc_write_en, IF_ID_write_en, ID_IE_write_en and IE_M_write_en all 0.
  - M_WB_bubble = 1.
  - Next state DSTALL; stay while dmem_busy.
  - On deassert, go to RUN, or to ISTALL / ISTALL_REDIR if that was the state on entry (a saved flag holds it).
  - The load completes in the cycle dmem_busy drops; M_WB_bubble = 0 that cycle.
- IE_pcSrc, not frozen:
  - IF_ID_flush = 1 and ID_IE_bubble = 1; pc_write_en = 1.
  - If imem_busy is also high, go to ISTALL_REDIR.
  - Overrides load_use in the same cycle, because the load-use consumer is wrong-path.
- load_use in RUN:
  - One-cycle stall: pc_write_en = 0, IF_ID_write_en = 0, ID_IE_bubble = 1.
  - No state change. The next cycle re-evaluates naturally, since the bubble clears IE_memRead.
- imem_busy in RUN:
  - pc_write_en = 0, IF_ID_flush = 1; downstream stages keep flowing.
  - Go to ISTALL; leave to RUN when imem_busy = 0.
- ISTALL_REDIR:
  - pc_write_en = 0, IF_ID_flush = 1 while imem_busy.
  - On the first cycle imem_busy = 0, force IF_ID_flush = 1 to discard the stale wrong-path word, let pc_write_en = 1 fetch the target, then go to RUN.
- A new IE_pcSrc in ISTALL behaves as it does in RUN, so the state becomes ISTALL_REDIR.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, add outputs:
  - lu_stall_cnt, 16 bits.
  - dmem_stall_cnt, 16 bits.
  - imem_stall_cnt, 16 bits.
  - flush_cnt, 16 bits.
- Each counter increments once per cycle in which its condition drives a stall or flush, and saturates at 16'hFFFF.
- All counters clear on rst.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Decomposition:
- Shared package/include: state encodings ST_RUN, ST_DSTALL, ST_ISTALL, ST_ISTALL_REDIR; field positions RS_HI/LO=10/8 and RT_HI/LO=7/5; NOP encoding.
- One natural sub-module: hazard_perf_counters, instantiated only under the macro.

Test Plan:
- Load-use: IE_memRead=1, IE_regWrite=1, IE_writereg=3, ID rs=3, ID_usesRs=1 -> for exactly 1 cycle pc_write_en=0, IF_ID_write_en=0, ID_IE_bubble=1; next cycle all enables=1.
- D-miss: dmem_busy high for 5 cycles -> pc, IF_ID, ID_IE and IE_M enables 0 and M_WB_bubble=1 for 5 cycles; stall_state=01; RUN on the 6th cycle.
- I-miss: imem_busy high for 3 cycles -> pc_write_en=0 and IF_ID_flush=1 for 3 cycles with ID_IE_write_en=1; then RUN.
- Redirect during I-miss: imem_busy=1 and IE_pcSrc pulses -> state 11; on the cycle imem_busy falls, IF_ID_flush=1 and pc_write_en=1; RUN on the following cycle.
- Branch plus load-use in the same cycle: IE_pcSrc=1 with a matching load_use -> flush behaviour only, pc_write_en=1.
- Reset during DSTALL: rst=1 with dmem_busy=1 -> next cycle state 00 and all enables 1; with HAZARD_PERF_CNT_EN, all counters read 0.
